// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle unsigned 16x16 multiplier (low 16 product bits)
// that borrows the shared Hack ALU and runs a shift-and-add sequence on it.
// Each multiplier bit takes one ADD cycle (acc += mcand or acc += 0) and one
// DBL cycle (mcand += mcand, mplier >>= 1). All outputs, including the ALU
// operands and control bits, are registered and set up for the state that
// is being entered.
//
// Optional feature: define ALU_MUL_OVF_EN to build the sticky unsigned
// overflow detector. Without it, ovf is tied to 0.
module alu_mul_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] mul_a,
  input  logic [15:0] mul_b,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DBL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // ALU control words, ordered {zx, nx, zy, ny, f, no}.
  localparam logic [5:0] CTRL_ZERO = 6'b101010; // constant 0
  localparam logic [5:0] CTRL_ADD  = 6'b000010; // x + y
  localparam logic [5:0] CTRL_X    = 6'b001010; // x + 0

  state_t      state, state_n;
  logic [15:0] acc, acc_n;
  logic [15:0] mcand, mcand_n;
  logic [15:0] mplier, mplier_n;
  logic [15:0] mplier_sh;
  logic [15:0] product_n;
  logic [15:0] alu_x_n, alu_y_n;
  logic [5:0]  ctrl, ctrl_n;
  logic        accept;

  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctrl;

  assign mplier_sh = mplier >> 1;
  assign accept    = ((state == IDLE) || (state == DONE)) && start;

  // Next-state and datapath update for the shift-and-add sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    mplier_n  = mplier;
    product_n = product;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          acc_n     = '0;
          mcand_n   = mul_a;
          mplier_n  = mul_b;
          product_n = '0;
          state_n   = (mul_b == 16'd0) ? DONE : ADD;
        end else begin
          state_n = IDLE;
        end
      end
      ADD: begin
        acc_n   = alu_out;
        state_n = DBL;
      end
      DBL: begin
        mcand_n  = alu_out;
        mplier_n = mplier_sh;
        if (mplier_sh == 16'd0) begin
          state_n   = DONE;
          product_n = acc;
        end else begin
          state_n = ADD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ALU operands and controls for the state being entered next.
  always_comb begin
    alu_x_n = '0;
    alu_y_n = '0;
    ctrl_n  = CTRL_ZERO;
    case (state_n)
      ADD: begin
        alu_x_n = acc_n;
        alu_y_n = mcand_n;
        ctrl_n  = mplier_n[0] ? CTRL_ADD : CTRL_X;
      end
      DBL: begin
        alu_x_n = mcand_n;
        alu_y_n = mcand_n;
        ctrl_n  = CTRL_ADD;
      end
      default: ;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      alu_x   <= '0;
      alu_y   <= '0;
      ctrl    <= CTRL_ZERO;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      mplier  <= mplier_n;
      product <= product_n;
      alu_x   <= alu_x_n;
      alu_y   <= alu_y_n;
      ctrl    <= ctrl_n;
      busy    <= (state_n == ADD) || (state_n == DBL);
      done    <= (state_n == DONE);
    end
  end

`ifdef ALU_MUL_OVF_EN
  logic ovf_acc, ovf_acc_n, ovf_n;

  // Sticky overflow for the current request; published on entry to DONE.
  always_comb begin
    ovf_acc_n = ovf_acc;
    ovf_n     = ovf;
    if (accept) begin
      ovf_acc_n = 1'b0;
      ovf_n     = 1'b0;
    end else begin
      case (state)
        ADD: if (mplier[0] && (alu_out < acc)) ovf_acc_n = 1'b1;
        DBL: begin
          // A doubling that drops mcand[15] matters only if more bits remain.
          if (mcand[15] && (mplier_sh != 16'd0)) ovf_acc_n = 1'b1;
          if (mplier_sh == 16'd0) ovf_n = ovf_acc_n;
        end
        default: ;
      endcase
    end
  end

  // Overflow flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_acc <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ovf_acc <= ovf_acc_n;
      ovf     <= ovf_n;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed self-checking bench for alu_mul_seq. A behavioural
// Hack ALU closes the loop on the DUT's ALU ports; expected products,
// latencies (2k+1) and flags are hand-computed constants.
module tb_alu_mul_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mul_a, mul_b;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic        busy, done, ovf;
  logic [15:0] product;
  logic [5:0]  ctrl;

  int checks   = 0;
  int failures = 0;

`ifdef ALU_MUL_OVF_EN
  localparam logic OVF_WRAP = 1'b1;
`else
  localparam logic OVF_WRAP = 1'b0;
`endif

  alu_mul_seq dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_zx  (alu_zx),
    .alu_nx  (alu_nx),
    .alu_zy  (alu_zy),
    .alu_ny  (alu_ny),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic zx, input logic nx, input logic zy,
                                           input logic ny, input logic f, input logic no);
    logic [15:0] xa, ya, o;
    xa = zx ? 16'h0000 : x;
    xa = nx ? ~xa : xa;
    ya = zy ? 16'h0000 : y;
    ya = ny ? ~ya : ya;
    o  = f ? (xa + ya) : (xa & ya);
    return no ? ~o : o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no);
  assign ctrl    = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Presents a request at the current negedge and follows it until done or
  // a 60-cycle budget. cyc is the cycle on which done was seen (cycle 1 is
  // the one right after the accepting edge). With hold set, start stays high
  // and the operands switch to na/nb from cycle 1. A nonzero spur cycle
  // raises a one-cycle start pulse that must be ignored.
  task automatic run(input logic [15:0] a, input logic [15:0] b, input bit hold,
                     input logic [15:0] na, input logic [15:0] nb, input int spur,
                     output int cyc, output int busy_low, output logic [15:0] prod1);
    start    = 1'b1;
    mul_a    = a;
    mul_b    = b;
    cyc      = 0;
    busy_low = 0;
    prod1    = 16'hxxxx;
    do begin
      @(negedge clock);
      cyc++;
      if (!hold) start = 1'b0;
      if (hold && cyc == 1) begin
        mul_a = na;
        mul_b = nb;
      end
      if (cyc == 1) prod1 = product;
      if (spur != 0 && cyc == spur) begin
        start = 1'b1;
        mul_a = 16'h0005;
        mul_b = 16'h0005;
      end
      if (!done && !busy) busy_low++;
    end while (!done && cyc < 60);
  endtask

  initial begin
    int cyc, busy_low, dones;
    logic [15:0] prod1;

    reset = 1'b1;
    start = 1'b0;
    mul_a = '0;
    mul_b = '0;
    repeat (2) @(negedge clock);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_product", product, 16'h0000);
    check("rst_ovf", 16'(ovf), 16'h0);
    check("rst_alu_x", alu_x, 16'h0000);
    check("rst_alu_y", alu_y, 16'h0000);
    check("rst_ctrl", 16'(ctrl), 16'h002A);
    reset = 1'b0;
    @(negedge clock);

    // Reset in the first ADD cycle of 3*5 aborts without a done pulse.
    start = 1'b1;
    mul_a = 16'd3;
    mul_b = 16'd5;
    @(negedge clock);
    start = 1'b0;
    check("mid_busy", 16'(busy), 16'h1);
    check("mid_alu_y", alu_y, 16'h0003);
    check("mid_ctrl", 16'(ctrl), 16'h0002);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_alu_y", alu_y, 16'h0000);
    check("abort_ctrl", 16'(ctrl), 16'h002A);
    check("abort_product", product, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);

    // 7*6: 6 = 110b, k=3, L=7.
    run(16'd7, 16'd6, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("m7x6_lat", 16'(cyc), 16'd7);
    check("m7x6_product", product, 16'd42);
    check("m7x6_ovf", 16'(ovf), 16'h0);
    @(negedge clock);

    // 3*5: 5 = 101b, k=3, L=7, busy on cycles 1-6.
    run(16'd3, 16'd5, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("m3x5_lat", 16'(cyc), 16'd7);
    check("m3x5_product", product, 16'h000F);
    check("m3x5_ovf", 16'(ovf), 16'h0);
    check("m3x5_busy_gap", 16'(busy_low), 16'd0);
    check("m3x5_prod_cleared", prod1, 16'h0000);
    repeat (3) @(negedge clock);
    check("m3x5_hold", product, 16'h000F);
    check("idle_done", 16'(done), 16'h0);
    check("idle_busy", 16'(busy), 16'h0);

    // Zero multiplier: straight to DONE, ALU stays on constant 0.
    run(16'h1234, 16'h0000, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("zero_lat", 16'(cyc), 16'd1);
    check("zero_product", product, 16'h0000);
    check("zero_ctrl", 16'(ctrl), 16'h002A);
    check("zero_alu_x", alu_x, 16'h0000);
    check("zero_alu_y", alu_y, 16'h0000);
    @(negedge clock);

    // Longest run, with a start pulse at cycle 10 that must be ignored.
    run(16'h0001, 16'h8000, 1'b0, 16'd0, 16'd0, 10, cyc, busy_low, prod1);
    check("long_lat", 16'(cyc), 16'd33);
    check("long_product", product, 16'h8000);
    check("long_ovf", 16'(ovf), 16'h0);
    dones = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dones++;
    end
    check("long_extra_done", 16'(dones), 16'd0);

    // 0x0100*0x0100 wraps to 0; bit 8 set so k=9, L=19.
    run(16'h0100, 16'h0100, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("wrap_lat", 16'(cyc), 16'd19);
    check("wrap_product", product, 16'h0000);
    check("wrap_ovf", 16'(ovf), 16'(OVF_WRAP));
    @(negedge clock);

    // 0xFFFF*1 fits exactly; k=1, L=3.
    run(16'hFFFF, 16'h0001, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("ffff_lat", 16'(cyc), 16'd3);
    check("ffff_product", product, 16'hFFFF);
    check("ffff_ovf", 16'(ovf), 16'h0);
    @(negedge clock);

    // Back-to-back: 2*3 (L=5) with start held, 4*4 (L=7) accepted in DONE.
    run(16'd2, 16'd3, 1'b1, 16'd4, 16'd4, 0, cyc, busy_low, prod1);
    check("b2b_first_lat", 16'(cyc), 16'd5);
    check("b2b_first_product", product, 16'd6);
    run(16'd4, 16'd4, 1'b0, 16'd0, 16'd0, 0, cyc, busy_low, prod1);
    check("b2b_second_lat", 16'(cyc), 16'd7);
    check("b2b_no_idle_gap", 16'(busy_low), 16'd0);
    check("b2b_prod_cleared", prod1, 16'h0000);
    check("b2b_second_product", product, 16'd16);
    check("b2b_second_ovf", 16'(ovf), 16'h0);
    @(negedge clock);
    check("b2b_done_pulse", 16'(done), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
